regbank_seq_ctrl: RTL and testbench
===================================

// Module: regbank_seq_ctrl
// PURPOSE
//   Multi-cycle sequencer that executes 3-address ALU ops on the 8x8 register bank.
//   Accepts one instruction per valid/ready handshake and drives the bank's two read ports.
//   Also drives the bank's write port (ra1/ra2/rd1/rd2, wa5/we5/wd32).
//   Enforces the bank's write-to-readback latency with a hazard interlock. X0 is never written.
// PARAMETERS
//   WB_LAT  2  cycles after a we5 pulse before the written value appears on rd1/rd2 (1..7)
// PORTS
//   clk        in   1   clock, all state on rising edge
//   rst        in   1   synchronous, active-high reset
//   in_valid   in   1   instruction offered
//   in_ready   out  1   controller can accept an instruction
//   in_instr   in   20  {op[19:17], rd[16:14], rs1[13:11], rs2[10:8], imm[7:0]}
//   ra1, ra2   out  3   bank read addresses
//   rd1, rd2   in   8   bank read data (combinational from ra1/ra2)
//   we5        out  1   bank write enable
//   wa5        out  3   bank write address
//   wd32       out  8   bank write data
//   done       out  1   one-cycle pulse when an instruction retires
//   done_data  out  8   result of the retiring instruction (valid while done=1)
//   busy       out  1   state != IDLE
// BEHAVIOUR
//   Ops (8-bit, mod 256, carry/borrow discarded):
//     000 NOP, 001 ADD rs1+rs2, 010 SUB rs1-rs2 (two's compl.), 011 AND, 100 OR, 101 XOR,
//     110 LI rd=imm, 111 MOV rd=rs1.
//   FSM states: IDLE, HAZ, RD, EX, WB.
//   IDLE: in_ready=1. On in_valid&&in_ready, latch in_instr. Next state:
//     - NOP or LI -> EX.
//     - Source matches pend_rd while haz_cnt!=0 -> HAZ. Sources are rs1/rs2 for ADD..XOR, rs1 only for MOV.
//     - Otherwise -> RD.
//   HAZ: hold. -> RD on the cycle haz_cnt==0.
//   RD: ra1=rs1, ra2=rs2. Capture rd1/rd2 into operand regs at the edge. -> EX.
//   EX: compute result into res reg. -> WB.
//   WB:
//     - done=1, done_data=res.
//     - If op!=NOP and rd!=0: we5=1, wa5=rd, wd32=res; load haz_cnt=WB_LAT; pend_rd=rd.
//     - -> IDLE.
//   haz_cnt: decrements by 1 every cycle while nonzero, in every state. A WB load overrides the decrement.
//   Latency (no hazard): ALU op accepted at edge N, RD N+1, EX N+2, WB N+3, in_ready at N+4.
//     LI/NOP retire one cycle sooner (WB at N+2).
//   rd==0: result computed and reported on done/done_data, but we5 stays 0 and haz_cnt is not loaded.
//   Source == 0 never stalls (X0 reads 0).
//   Idle outputs: when not in RD, ra1=ra2=0. When not in WB, we5=0, wa5=0, wd32=0, done=0, done_data=0.
//   in_ready=0 in every state except IDLE. in_instr is ignored when in_ready=0.
//   Reset (any state, including mid-instruction):
//     - Next state IDLE; all outputs 0 during the reset cycle (in_ready=0, we5=0).
//     - haz_cnt=0, pend_rd=0, operand/res regs=0.
//     - The aborted instruction never writes and never signals done.
//     - in_ready=1 on the first cycle after rst deasserts.
// TESTING
//   1. rst 2 cycles; check all outputs 0. Release; check in_ready=1 next cycle, busy=0.
//   2. LI r1=0x7F, LI r2=0x02, ADD r3=r1+r2 -> we5 wa5=3 wd32=0x81; done_data=0x81.
//      ADD WB occurs 3 cycles after accept, plus any hazard stall from LI r2.
//   3. Wrap: LI r1=0xFF, LI r2=0x01; ADD r4 -> 0x00; SUB r5=r2-r1 -> 0x02. No carry visible.
//   4. Hazard (WB_LAT=2): LI r1=0x55 then MOV r2=r1 back-to-back -> MOV holds in HAZ until haz_cnt=0.
//      RD then samples 0x55; wd32=0x55 for wa5=2.
//   5. rd=0: ADD r0=r1+r2 -> done=1, done_data=sum, we5 stays 0. A following op sourcing r0 does not stall.
//   6. Assert rst during EX of an ADD -> no we5 pulse, no done. Post-reset LI r6=0x3C works normally.

Source files
------------

// File: rtl/regbank_seq_ctrl_if.sv
// Bundles the instruction handshake, register-bank ports and status of the sequencer.
// No logic lives here. The controller takes the slave side.
// The bench, which models the instruction source and the bank, takes the master side.
interface regbank_seq_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] in_instr;
   logic [2:0]  ra1;
   logic [2:0]  ra2;
   logic [7:0]  rd1;
   logic [7:0]  rd2;
   logic        we5;
   logic [2:0]  wa5;
   logic [7:0]  wd32;
   logic        done;
   logic [7:0]  done_data;
   logic        busy;

   modport slave (
      input  in_valid, in_instr, rd1, rd2,
      output in_ready, ra1, ra2, we5, wa5, wd32, done, done_data, busy
   );

   modport master (
      output in_valid, in_instr, rd1, rd2,
      input  in_ready, ra1, ra2, we5, wa5, wd32, done, done_data, busy
   );
endinterface

// File: rtl/regbank_seq_ctrl.sv
// Purpose: multi-cycle sequencer for 3-address ALU ops on an 8x8 register bank. It has a write-to-read hazard interlock.
// Latency: an ALU op retires 3 cycles after accept, and LI/NOP retire 2 cycles after accept. A hazard adds stall cycles.
// Backpressure: in_ready is high only in IDLE. An instruction is taken on in_valid && in_ready.
module regbank_seq_ctrl #(
   parameter int WB_LAT = 2
) (
   input  logic               clk,
   input  logic               rst,
   regbank_seq_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {S_IDLE, S_HAZ, S_RD, S_EX, S_WB} state_t;

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_OR  = 3'd4;
   localparam logic [2:0] OP_XOR = 3'd5;
   localparam logic [2:0] OP_LI  = 3'd6;
   localparam logic [2:0] OP_MOV = 3'd7;

   state_t      state_q, state_d;
   logic [19:0] instr_q, instr_d;
   logic [7:0]  opa_q, opa_d;
   logic [7:0]  opb_q, opb_d;
   logic [7:0]  res_q, res_d;
   logic [2:0]  haz_cnt_q, haz_cnt_d;
   logic [2:0]  pend_rd_q, pend_rd_d;

   // Fields of the latched instruction and of the instruction on offer
   logic [2:0] op_q, rd_q, rs1_q, rs2_q;
   logic [7:0] imm_q;
   logic [2:0] in_op, in_rs1, in_rs2;
   logic       in_haz;

   assign op_q   = instr_q[19:17];
   assign rd_q   = instr_q[16:14];
   assign rs1_q  = instr_q[13:11];
   assign rs2_q  = instr_q[10:8];
   assign imm_q  = instr_q[7:0];
   assign in_op  = bus.in_instr[19:17];
   assign in_rs1 = bus.in_instr[13:11];
   assign in_rs2 = bus.in_instr[10:8];

   // Pre-gating output values. They are forced to zero while rst is high.
   logic       in_ready_c, we5_c, done_c;
   logic [2:0] ra1_c, ra2_c, wa5_c;
   logic [7:0] wd32_c, done_data_c;

   // Stall if a real source register (never X0) is still in flight through the bank write path. MOV reads rs1 only.
   always_comb begin
      in_haz = 1'b0;
      if (haz_cnt_q != 3'd0) begin
         if (in_rs1 != 3'd0 && in_rs1 == pend_rd_q)
            in_haz = 1'b1;
         if (in_op != OP_MOV && in_rs2 != 3'd0 && in_rs2 == pend_rd_q)
            in_haz = 1'b1;
      end
   end

   // Next-state, datapath and output decode
   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      res_d       = res_q;
      pend_rd_d   = pend_rd_q;
      haz_cnt_d   = (haz_cnt_q != 3'd0) ? haz_cnt_q - 3'd1 : 3'd0;
      in_ready_c  = 1'b0;
      ra1_c       = 3'd0;
      ra2_c       = 3'd0;
      we5_c       = 1'b0;
      wa5_c       = 3'd0;
      wd32_c      = 8'd0;
      done_c      = 1'b0;
      done_data_c = 8'd0;

      case (state_q)
         S_IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               instr_d = bus.in_instr;
               if (in_op == OP_NOP || in_op == OP_LI)
                  state_d = S_EX;
               else if (in_haz)
                  state_d = S_HAZ;
               else
                  state_d = S_RD;
            end
         end
         S_HAZ: begin
            if (haz_cnt_q == 3'd0)
               state_d = S_RD;
         end
         S_RD: begin
            ra1_c   = rs1_q;
            ra2_c   = rs2_q;
            opa_d   = bus.rd1;
            opb_d   = bus.rd2;
            state_d = S_EX;
         end
         S_EX: begin
            case (op_q)
               OP_ADD:  res_d = opa_q + opb_q;
               OP_SUB:  res_d = opa_q - opb_q;
               OP_AND:  res_d = opa_q & opb_q;
               OP_OR:   res_d = opa_q | opb_q;
               OP_XOR:  res_d = opa_q ^ opb_q;
               OP_LI:   res_d = imm_q;
               OP_MOV:  res_d = opa_q;
               default: res_d = 8'd0;
            endcase
            state_d = S_WB;
         end
         S_WB: begin
            done_c      = 1'b1;
            done_data_c = res_q;
            if (op_q != OP_NOP && rd_q != 3'd0) begin
               we5_c     = 1'b1;
               wa5_c     = rd_q;
               wd32_c    = res_q;
               haz_cnt_d = 3'(WB_LAT);
               pend_rd_d = rd_q;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // All outputs read zero during the reset cycle, whatever state the FSM held
   assign bus.in_ready  = rst ? 1'b0 : in_ready_c;
   assign bus.ra1       = rst ? 3'd0 : ra1_c;
   assign bus.ra2       = rst ? 3'd0 : ra2_c;
   assign bus.we5       = rst ? 1'b0 : we5_c;
   assign bus.wa5       = rst ? 3'd0 : wa5_c;
   assign bus.wd32      = rst ? 8'd0 : wd32_c;
   assign bus.done      = rst ? 1'b0 : done_c;
   assign bus.done_data = rst ? 8'd0 : done_data_c;
   assign bus.busy      = rst ? 1'b0 : (state_q != S_IDLE);

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         instr_q   <= 20'd0;
         opa_q     <= 8'd0;
         opb_q     <= 8'd0;
         res_q     <= 8'd0;
         haz_cnt_q <= 3'd0;
         pend_rd_q <= 3'd0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         res_q     <= res_d;
         haz_cnt_q <= haz_cnt_d;
         pend_rd_q <= pend_rd_d;
      end
   end

endmodule

// File: tb/tb_regbank_seq_ctrl.sv
// Directed bench for regbank_seq_ctrl with a behavioural register bank.
// The bank makes a written value readable WB_LAT+1 cycles after the we5 pulse.
// Latency is counted in cycles from the accept cycle to the WB cycle.
module tb_regbank_seq_ctrl;
   localparam int WB_LAT = 2;

   localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3;
   localparam logic [2:0] OR_ = 3'd4, XOR_ = 3'd5, LI = 3'd6, MOV = 3'd7;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regbank_seq_ctrl_if bus();

   regbank_seq_ctrl #(.WB_LAT(WB_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int wr_pulses = 0;

   // Register bank model: combinational reads, delayed write commit, X0 hard-wired to 0
   logic [7:0] mem [8];
   logic       pv [WB_LAT];
   logic [2:0] pa [WB_LAT];
   logic [7:0] pd [WB_LAT];

   assign bus.rd1 = (bus.ra1 == 3'd0) ? 8'h00 : mem[bus.ra1];
   assign bus.rd2 = (bus.ra2 == 3'd0) ? 8'h00 : mem[bus.ra2];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && bus.we5) wr_pulses <= wr_pulses + 1;
      if (rst) begin
         for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
         for (int i = 0; i < WB_LAT; i++) pv[i] <= 1'b0;
      end else begin
         if (pv[WB_LAT-1]) mem[pa[WB_LAT-1]] <= pd[WB_LAT-1];
         for (int i = WB_LAT-1; i > 0; i--) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
            pd[i] <= pd[i-1];
         end
         pv[0] <= bus.we5;
         pa[0] <= bus.wa5;
         pd[0] <= bus.wd32;
      end
   end

   function automatic logic [19:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [7:0] imm);
      return {op, rd, rs1, rs2, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [28:0] all_outs();
      return {bus.in_ready, bus.ra1, bus.ra2, bus.we5, bus.wa5, bus.wd32,
              bus.done, bus.done_data, bus.busy};
   endfunction

   // Offer an instruction and hold it until accepted. acc is the edge count just after the accept edge.
   task automatic issue(input logic [19:0] ins, output int acc);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_instr = ins;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.in_ready && n < 50);
      chk("issue_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      acc = cyc;
      bus.in_valid = 1'b0;
      bus.in_instr = 20'd0;
   endtask

   // Wait for the done pulse (bounded), then check latency, result and write port
   task automatic retire(input string tag, input int acc, input int lat, input logic [7:0] data,
                         input logic we, input logic [2:0] wa);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done && n < 40);
      chk({tag, "_done"},  32'(bus.done), 32'd1);
      chk({tag, "_lat"},   32'(cyc - acc + 1), 32'(lat));
      chk({tag, "_data"},  32'(bus.done_data), 32'(data));
      chk({tag, "_we5"},   32'(bus.we5), 32'(we));
      chk({tag, "_wa5"},   32'(bus.wa5), we ? 32'(wa) : 32'd0);
      chk({tag, "_wd32"},  32'(bus.wd32), we ? 32'(data) : 32'd0);
      chk({tag, "_busy"},  32'(bus.busy), 32'd1);
   endtask

   task automatic run(input string tag, input logic [19:0] ins, input int lat,
                      input logic [7:0] data, input logic we, input logic [2:0] wa);
      int acc;
      issue(ins, acc);
      retire(tag, acc, lat, data, we, wa);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int pulses0;
      int seen;

      // Reset for two cycles; every output reads zero while rst is high
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_instr = 20'd0;
      repeat (2) @(negedge clk);
      chk("reset_outs", 32'(all_outs()), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_reset_ready", 32'(bus.in_ready), 32'd1);
      chk("post_reset_busy",  32'(bus.busy), 32'd0);

      // Basic add. ADD stalls on r2, which LI wrote just before.
      run("li_r1",    mk(LI,  3'd1, 3'd0, 3'd0, 8'h7F), 2, 8'h7F, 1'b1, 3'd1);
      run("li_r2",    mk(LI,  3'd2, 3'd0, 3'd0, 8'h02), 2, 8'h02, 1'b1, 3'd2);
      run("add_r3",   mk(ADD, 3'd3, 3'd1, 3'd2, 8'h00), 5, 8'h81, 1'b1, 3'd3);

      // Wrap-around with no visible carry or borrow
      run("li_r1ff",  mk(LI,  3'd1, 3'd0, 3'd0, 8'hFF), 2, 8'hFF, 1'b1, 3'd1);
      run("li_r2_01", mk(LI,  3'd2, 3'd0, 3'd0, 8'h01), 2, 8'h01, 1'b1, 3'd2);
      run("add_wrap", mk(ADD, 3'd4, 3'd1, 3'd2, 8'h00), 5, 8'h00, 1'b1, 3'd4);
      run("sub_r5",   mk(SUB, 3'd5, 3'd2, 3'd1, 8'h00), 3, 8'h02, 1'b1, 3'd5);
      run("and_r6",   mk(AND_,3'd6, 3'd1, 3'd2, 8'h00), 3, 8'h01, 1'b1, 3'd6);
      run("or_r7",    mk(OR_, 3'd7, 3'd4, 3'd2, 8'h00), 3, 8'h01, 1'b1, 3'd7);
      run("xor_r3",   mk(XOR_,3'd3, 3'd1, 3'd5, 8'h00), 3, 8'hFD, 1'b1, 3'd3);

      // MOV back-to-back on a fresh write holds in HAZ and then reads the new value
      run("li_55",    mk(LI,  3'd1, 3'd0, 3'd0, 8'h55), 2, 8'h55, 1'b1, 3'd1);
      run("mov_haz",  mk(MOV, 3'd2, 3'd1, 3'd0, 8'h00), 5, 8'h55, 1'b1, 3'd2);
      // MOV ignores rs2 even when it matches the pending register
      run("li_r7_11", mk(LI,  3'd7, 3'd0, 3'd0, 8'h11), 2, 8'h11, 1'b1, 3'd7);
      run("mov_rs2",  mk(MOV, 3'd3, 3'd5, 3'd7, 8'h00), 3, 8'h02, 1'b1, 3'd3);

      // rd = 0: the result is reported but never written; X0 sources never stall
      run("add_r0",   mk(ADD, 3'd0, 3'd1, 3'd2, 8'h00), 3, 8'hAA, 1'b0, 3'd0);
      run("add_src0", mk(ADD, 3'd6, 3'd0, 3'd1, 8'h00), 3, 8'h55, 1'b1, 3'd6);
      run("nop",      mk(NOP, 3'd5, 3'd1, 3'd2, 8'h00), 2, 8'h00, 1'b0, 3'd0);
      run("li_r0",    mk(LI,  3'd0, 3'd0, 3'd0, 8'h9A), 2, 8'h9A, 1'b0, 3'd0);

      // Reset in EX aborts the ADD with no write and no done
      issue(mk(ADD, 3'd7, 3'd1, 3'd2, 8'h00), acc);
      pulses0 = wr_pulses;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("abort_reset_outs", 32'(all_outs()), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_ready", 32'(bus.in_ready), 32'd1);
      chk("abort_busy",  32'(bus.busy), 32'd0);
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      chk("abort_no_done",  32'(seen), 32'd0);
      chk("abort_no_write", 32'(wr_pulses - pulses0), 32'd0);

      run("li_r6_post", mk(LI,  3'd6, 3'd0, 3'd0, 8'h3C), 2, 8'h3C, 1'b1, 3'd6);
      run("mov_post",   mk(MOV, 3'd7, 3'd6, 3'd0, 8'h00), 5, 8'h3C, 1'b1, 3'd7);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
